// File: rtl/ysyx_24100005_exec_ctrl.sv
// ysyx_24100005_exec_ctrl
//   Multi-cycle fetch/execute sequencer for the NPC core. It owns the PC and
//   fetches one instruction at a time over a valid/ready port. The fetched word
//   is latched for the decode/execute datapath. Each instruction gets one
//   register-file write and one PC update. The core stops on ebreak, on an
//   unsupported opcode, or (optionally) when a fetch times out.
//
//   Optional feature macro: YSYX_24100005_FETCH_TIMEOUT_EN
//     defined   -> an 8-bit FETCH_WAIT cycle counter bounds the fetch wait to
//                  TIMEOUT cycles; expiry raises fetch_err and halts.
//     undefined -> no counter; FETCH_WAIT waits forever; fetch_err is tied 0.
//
// Parameters
//   RESET_PC  PC value loaded on reset
//   TIMEOUT   maximum number of FETCH_WAIT cycles (1..255, timeout build only)
//
// Ports
//   clk, rst        core clock / asynchronous active-high reset
//   ifu_req_valid   fetch request valid (FETCH_REQ only)
//   ifu_req_ready   memory accepts the request
//   ifu_req_addr    fetch address, always equal to pc
//   ifu_rsp_valid   instruction data valid (sampled in FETCH_WAIT only)
//   ifu_rsp_data    instruction word
//   next_pc         next PC from the datapath
//   inst            latched instruction for decode
//   pc              current PC
//   rf_wen          register-file write enable, combinational, EXEC only
//   retire_cnt      retired-instruction count (wraps mod 2^32)
//   halt            sticky: core stopped
//   illegal         sticky: the halt was caused by an unsupported opcode
//   fetch_err       sticky: the halt was caused by a fetch timeout
module ysyx_24100005_exec_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_data,
  input  logic [31:0] next_pc,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        rf_wen,
  output logic [31:0] retire_cnt,
  output logic        halt,
  output logic        illegal,
  output logic        fetch_err
);

  localparam logic [1:0] FETCH_REQ  = 2'd0;
  localparam logic [1:0] FETCH_WAIT = 2'd1;
  localparam logic [1:0] EXEC       = 2'd2;
  localparam logic [1:0] HALT       = 2'd3;

  localparam logic [31:0] EBREAK    = 32'h0010_0073;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  logic [1:0]  state_q,   state_d;
  logic [31:0] pc_q,      pc_d;
  logic [31:0] inst_q,    inst_d;
  logic [31:0] retire_q,  retire_d;
  logic        halt_q,    halt_d;
  logic        illegal_q, illegal_d;

  logic is_ebreak;
  logic is_opimm;
  logic rd_nonzero;

  assign is_ebreak  = (inst_q == EBREAK);
  assign is_opimm   = (inst_q[6:0] == OP_IMM);
  assign rd_nonzero = (inst_q[11:7] != 5'd0);

`ifdef YSYX_24100005_FETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       fetch_err_q, fetch_err_d;
  logic       wait_expire;

  // The cycle being spent now is number wait_cnt_q+1. When that count hits
  // TIMEOUT without a response, the wait expires at the end of this cycle.
  assign wait_expire = ((wait_cnt_q + 8'd1) == TIMEOUT_W);
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    retire_d  = retire_q;
    halt_d    = halt_q;
    illegal_d = illegal_q;
`ifdef YSYX_24100005_FETCH_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    fetch_err_d = fetch_err_q;
`endif
    case (state_q)
      FETCH_REQ: begin
        // A response seen while the request is still pending is not ours.
        if (ifu_req_ready) begin
          state_d = FETCH_WAIT;
`ifdef YSYX_24100005_FETCH_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      FETCH_WAIT: begin
        if (ifu_rsp_valid) begin
          inst_d  = ifu_rsp_data;
          state_d = EXEC;
        end
`ifdef YSYX_24100005_FETCH_TIMEOUT_EN
        else if (wait_expire) begin
          fetch_err_d = 1'b1;
          halt_d      = 1'b1;
          state_d     = HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end
      EXEC: begin
        if (is_ebreak) begin
          retire_d = retire_q + 32'd1;
          halt_d   = 1'b1;
          state_d  = HALT;
        end else if (is_opimm) begin
          pc_d     = next_pc;
          retire_d = retire_q + 32'd1;
          state_d  = FETCH_REQ;
        end else begin
          halt_d    = 1'b1;
          illegal_d = 1'b1;
          state_d   = HALT;
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= NOP;
      retire_q  <= '0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retire_q  <= retire_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef YSYX_24100005_FETCH_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign ifu_req_valid = (state_q == FETCH_REQ);
  assign ifu_req_addr  = pc_q;
  assign rf_wen        = (state_q == EXEC) && is_opimm && rd_nonzero && !is_ebreak;
  assign inst          = inst_q;
  assign pc            = pc_q;
  assign retire_cnt    = retire_q;
  assign halt          = halt_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_ysyx_24100005_exec_ctrl.sv
// Self-checking bench for ysyx_24100005_exec_ctrl. The bench plays the memory
// side with directed and randomized handshake delays. A per-instruction
// reference model keeps the architectural state: pc, retire count and the
// sticky flags.
module tb_ysyx_24100005_exec_ctrl;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic [31:0] next_pc;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        rf_wen;
  logic [31:0] retire_cnt;
  logic        halt;
  logic        illegal;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc, m_inst, m_retire;
  logic        m_halt, m_illegal, m_ferr;

  ysyx_24100005_exec_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr), .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_data(ifu_rsp_data), .next_pc(next_pc),
    .inst(inst), .pc(pc), .rf_wen(rf_wen), .retire_cnt(retire_cnt),
    .halt(halt), .illegal(illegal), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] opimm(input logic [4:0] rd);
    opimm = {12'($urandom), 5'($urandom), 3'($urandom), rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] bad_word();
    logic [31:0] w;
    do w = $urandom; while (w[6:0] == 7'b0010011 || w == EBREAK);
    bad_word = w;
  endfunction

  task automatic check_arch(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".addr"}, ifu_req_addr, m_pc);
    chk({tag, ".inst"}, inst, m_inst);
    chk({tag, ".retire"}, retire_cnt, m_retire);
    chk({tag, ".halt"}, 32'(halt), 32'(m_halt));
    chk({tag, ".illegal"}, 32'(illegal), 32'(m_illegal));
    chk({tag, ".fetch_err"}, 32'(fetch_err), 32'(m_ferr));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    #1;
    m_pc = RESET_PC; m_inst = 32'h0000_0013; m_retire = '0;
    m_halt = 1'b0; m_illegal = 1'b0; m_ferr = 1'b0;
    check_arch("reset");
    chk("reset.rf_wen", 32'(rf_wen), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset.req_valid", 32'(ifu_req_valid), 32'd1);
    check_arch("post_reset");
  endtask

  // Runs one instruction from FETCH_REQ through EXEC, then updates the model.
  task automatic run_instr(input int rdy_wait, input int rsp_wait,
                           input logic [31:0] word, input logic [31:0] npc);
    next_pc = npc;
    for (int i = 0; i < rdy_wait; i++) begin
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = 1'($urandom);
      ifu_rsp_data  = $urandom;
      chk("req.valid_held", 32'(ifu_req_valid), 32'd1);
      chk("req.addr_held", ifu_req_addr, m_pc);
      chk("req.rf_wen", 32'(rf_wen), 32'd0);
      @(negedge clk);
    end
    chk("req.valid", 32'(ifu_req_valid), 32'd1);
    chk("req.addr", ifu_req_addr, m_pc);
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'($urandom);
    ifu_rsp_data  = $urandom;
    @(negedge clk);
    ifu_req_ready = 1'($urandom);
    for (int i = 0; i < rsp_wait; i++) begin
      ifu_rsp_valid = 1'b0;
      chk("wait.req_valid", 32'(ifu_req_valid), 32'd0);
      chk("wait.inst", inst, m_inst);
      chk("wait.pc", pc, m_pc);
      @(negedge clk);
    end
    chk("wait.req_valid", 32'(ifu_req_valid), 32'd0);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = word;
    @(negedge clk);
    m_inst = word;
    ifu_rsp_valid = 1'($urandom);
    ifu_rsp_data  = $urandom;
    chk("exec.inst", inst, word);
    chk("exec.pc", pc, m_pc);
    chk("exec.req_valid", 32'(ifu_req_valid), 32'd0);
    chk("exec.rf_wen", 32'(rf_wen),
        32'((word[6:0] == 7'b0010011) && (word[11:7] != 5'd0)));
    @(negedge clk);
    if (word == EBREAK) begin
      m_retire = m_retire + 1; m_halt = 1'b1;
    end else if (word[6:0] == 7'b0010011) begin
      m_pc = npc; m_retire = m_retire + 1;
    end else begin
      m_halt = 1'b1; m_illegal = 1'b1;
    end
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    check_arch("done");
    chk("done.rf_wen", 32'(rf_wen), 32'd0);
    chk("done.req_valid", 32'(ifu_req_valid), 32'(!m_halt));
  endtask

  task automatic hold_halt();
    for (int i = 0; i < 3; i++) begin
      ifu_req_ready = 1'b1;
      ifu_rsp_valid = 1'($urandom);
      ifu_rsp_data  = 32'h0050_0093;
      next_pc = $urandom;
      @(negedge clk);
      chk("halt.req_valid", 32'(ifu_req_valid), 32'd0);
      chk("halt.rf_wen", 32'(rf_wen), 32'd0);
      check_arch("halt");
    end
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_data = '0;
    next_pc = '0;

    // minimum-latency addi x1,x0,5
    do_reset();
    run_instr(0, 0, 32'h0050_0093, m_pc + 4);
    chk("first.pc", pc, 32'h8000_0004);
    chk("first.retire", retire_cnt, 32'd1);

    // back-pressure on request and delayed response
    run_instr(4, 3, opimm(5'd7), m_pc + 4);
    // rd = x0
    run_instr(0, 1, 32'h0000_0013, m_pc + 4);

    // ebreak after two addi
    do_reset();
    run_instr(1, 0, opimm(5'd3), m_pc + 4);
    run_instr(0, 2, opimm(5'd9), m_pc + 4);
    run_instr(0, 0, EBREAK, $urandom);
    chk("ebreak.retire", retire_cnt, 32'd3);
    chk("ebreak.pc", pc, RESET_PC + 32'd8);
    hold_halt();

    // illegal R-type
    do_reset();
    run_instr(0, 0, opimm(5'd1), m_pc + 4);
    run_instr(2, 1, 32'h0000_0033, $urandom);
    chk("illegal.flag", 32'(illegal), 32'd1);
    chk("illegal.retire", retire_cnt, 32'd1);
    hold_halt();
    do_reset();

    // randomized programs, unaligned next_pc allowed
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 25; n++)
        run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  opimm(5'($urandom)), $urandom);
      run_instr(0, 1, (r == 1) ? EBREAK : bad_word(), $urandom);
      hold_halt();
      do_reset();
    end

`ifdef YSYX_24100005_FETCH_TIMEOUT_EN
    // no response: halts after 4 wait cycles
    run_instr(0, 0, opimm(5'd2), m_pc + 4);
    ifu_req_ready = 1'b1;
    @(negedge clk);
    ifu_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to.wait_halt", 32'(halt), 32'd0);
      @(negedge clk);
    end
    m_halt = 1'b1; m_ferr = 1'b1;
    check_arch("timeout");
    hold_halt();
    // response on the 4th wait cycle wins
    do_reset();
    run_instr(0, 3, opimm(5'd4), m_pc + 4);
    chk("to.late_ok", 32'(fetch_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
